// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Serial UART transmitter that sends one bit per clock cycle. An accepted word
// goes out as: start bit (0), data bits LSB first, an optional parity bit,
// and a stop bit (1). Busy is high from the start bit through the stop bit.
// At least one idle cycle follows every frame, so Busy rises exactly once per
// frame. A downstream edge detector relies on this to pop the TX FIFO.
//
// Ports
//   CLK         in   1           TX clock, one cycle per bit period
//   RST         in   1           asynchronous active-low reset
//   P_DATA      in   DATA_WIDTH  parallel word to transmit
//   Data_Valid  in   1           P_DATA valid; sampled only while idle
//   PAR_EN      in   1           1 = append a parity bit
//   PAR_TYP     in   1           0 = even parity, 1 = odd parity
//   TX_OUT      out  1           serial line, idles high (registered)
//   Busy        out  1           frame in progress (registered)
// ---------------------------------------------------------------------------
module uart_tx_frame #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [CNT_W-1:0]      cnt_s;
   logic [DATA_WIDTH-1:0] data_r;
   logic                  par_en_r;
   logic                  par_bit_r;
   logic                  accept_s;
   logic                  tx_s;
   logic                  busy_s;

   // Parity bit over the word: even parity is the XOR of the bits, odd parity
   // is its complement.
   function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                        input logic                  odd);
      calc_parity = (^data) ^ odd;
   endfunction

   // State and bit-counter register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Latch the word and its framing options when a frame is accepted, so
   // input changes during the frame have no effect.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_r    <= {DATA_WIDTH{1'b0}};
         par_en_r  <= 1'b0;
         par_bit_r <= 1'b0;
      end else if (accept_s) begin
         data_r    <= P_DATA;
         par_en_r  <= PAR_EN;
         par_bit_r <= calc_parity(P_DATA, PAR_TYP);
      end else begin
         data_r    <= data_r;
         par_en_r  <= par_en_r;
         par_bit_r <= par_bit_r;
      end
   end

   // Next-state logic. Data_Valid is looked at only in IDLE, and STOP always
   // returns to IDLE. This forces the idle gap between frames.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (Data_Valid) begin
               accept_s = 1'b1;
               state_s  = START;
            end else begin
               state_s  = IDLE;
            end
         end
         START: begin
            state_s = DATA;
            cnt_s   = {CNT_W{1'b0}};
         end
         DATA: begin
            if (cnt_r == LAST_BIT) begin
               cnt_s   = {CNT_W{1'b0}};
               state_s = par_en_r ? PARITY : STOP;
            end else begin
               cnt_s   = cnt_r + CNT_W'(1);
               state_s = DATA;
            end
         end
         PARITY: begin
            state_s = STOP;
         end
         STOP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Output decode of the upcoming state. Registering it means the line
   // shows a state's bit in the same cycle the state register holds it.
   // The start bit therefore appears in the cycle right after acceptance.
   always_comb begin
      tx_s   = 1'b1;
      busy_s = 1'b0;
      case (state_s)
         IDLE: begin
            tx_s   = 1'b1;
            busy_s = 1'b0;
         end
         START: begin
            tx_s   = 1'b0;
            busy_s = 1'b1;
         end
         DATA: begin
            tx_s   = data_r[cnt_s];
            busy_s = 1'b1;
         end
         PARITY: begin
            tx_s   = par_bit_r;
            busy_s = 1'b1;
         end
         STOP: begin
            tx_s   = 1'b1;
            busy_s = 1'b1;
         end
         default: begin
            tx_s   = 1'b1;
            busy_s = 1'b0;
         end
      endcase
   end

   // Output registers; reset drives the line idle immediately.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         TX_OUT <= 1'b1;
         Busy   <= 1'b0;
      end else begin
         TX_OUT <= tx_s;
         Busy   <= busy_s;
      end
   end

endmodule
